// File: rtl/result_collector_pkg.sv
// Shared definitions for the matrix datapath: collector FSM encoding, default geometry and
// the BRAM region map used by the loader, flow controller and result collector.
package result_collector_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDone    = 2'd2
  } rc_state_e;

  localparam int unsigned DefNumResults = 9;
  localparam int unsigned DefAddrW      = 8;
  localparam int unsigned DefDataW      = 32;

  // BRAM word map: operand A, operand B, then the product region.
  localparam int unsigned ABaseAddr   = 0;
  localparam int unsigned BBaseAddr   = 9;
  localparam int unsigned ResBaseAddr = 18;

  localparam int unsigned DefBaseAddr = ResBaseAddr;

endpackage

// File: rtl/result_collector.sv
// Captures a stream of matrix-product words into the BRAM result region, keeps a local copy
// for readback, and tracks count, checksum, completion and late-beat overflow.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned NUM_RESULTS = DefNumResults,
  parameter int unsigned BASE_ADDR   = DefBaseAddr,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned DATA_W      = DefDataW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  input  logic              rd_en,
  input  logic [3:0]        rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [3:0]        count,
  output logic [DATA_W-1:0] checksum,
  output logic              done,
  output logic              overflow
);

  localparam logic [3:0] LastIdx = 4'(NUM_RESULTS - 1);

  rc_state_e         state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              accept;

  logic [DATA_W-1:0] buffer_q [NUM_RESULTS];

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_err_q, rd_err_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    accept     = 1'b0;

    if (clear) begin
      state_d    = StIdle;
      count_d    = '0;
      checksum_d = '0;
      done_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StCapture: begin
          if (in_valid) begin
            accept     = 1'b1;
            we_d       = 1'b1;
            addr_d     = ADDR_W'(BASE_ADDR) + ADDR_W'(count_q);
            data_d     = in_data;
            count_d    = count_q + 4'd1;
            checksum_d = checksum_q + in_data;
            if (count_q == LastIdx) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StCapture;
            end
          end
        end
        StDone: begin
          if (in_valid) overflow_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      checksum_q <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // Buffer has no reset; it survives clear so a finished product stays readable.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      buffer_q[count_q] <= in_data;
    end
  end

  always_comb begin
    rd_data_d = '0;
    rd_err_d  = 1'b0;
    if (rd_en) begin
      if (32'(rd_idx) >= NUM_RESULTS) begin
        rd_err_d = 1'b1;
      end else begin
        rd_data_d = buffer_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      rd_err_q   <= rd_err_d;
    end
  end

  assign bram_addr = addr_q;
  assign bram_data = data_q;
  assign bram_we   = we_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign count     = count_q;
  assign checksum  = checksum_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: streaming, gaps, overflow, reset abort and readback.
module tb_result_collector;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [31:0] in_data;
  logic        in_valid;
  logic [7:0]  bram_addr;
  logic [31:0] bram_data;
  logic        bram_we;
  logic        rd_en;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic [3:0]  count;
  logic [31:0] checksum;
  logic        done;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  result_collector dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .bram_addr (bram_addr),
    .bram_data (bram_data),
    .bram_we   (bram_we),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err),
    .count     (count),
    .checksum  (checksum),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and checks both live 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    rd_en    = 1'b0;
    rd_idx   = '0;
    step();
    step();
    reset = 1'b0;

    check("rst_we",       32'(bram_we),   32'd0);
    check("rst_addr",     32'(bram_addr), 32'd0);
    check("rst_data",     bram_data,      32'd0);
    check("rst_rd_data",  rd_data,        32'd0);
    check("rst_rd_valid", 32'(rd_valid),  32'd0);
    check("rst_rd_err",   32'(rd_err),    32'd0);
    check("rst_count",    32'(count),     32'd0);
    check("rst_checksum", checksum,       32'd0);
    check("rst_done",     32'(done),      32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);

    // Back-to-back 1..9
    for (int i = 1; i <= 9; i++) begin
      beat(32'(i));
      check("b2b_we",    32'(bram_we),   32'd1);
      check("b2b_addr",  32'(bram_addr), 32'(17 + i));
      check("b2b_data",  bram_data,      32'(i));
      check("b2b_count", 32'(count),     32'(i));
      check("b2b_done",  32'(done),      32'(i == 9));
    end
    step();
    check("b2b_idle_we",  32'(bram_we), 32'd0);
    check("b2b_count9",   32'(count),   32'd9);
    check("b2b_checksum", checksum,     32'd45);
    check("b2b_done_hold", 32'(done),   32'd1);

    do_clear();
    check("clr_count",    32'(count),    32'd0);
    check("clr_done",     32'(done),     32'd0);
    check("clr_checksum", checksum,      32'd0);

    // Gapped run with 10*i; a same-cycle read of the word being written sees the old value.
    for (int i = 1; i <= 9; i++) begin
      rd_en  = 1'b1;
      rd_idx = 4'(i - 1);
      beat(32'(10 * i));
      rd_en = 1'b0;
      check("gap_we",      32'(bram_we),   32'd1);
      check("gap_addr",    32'(bram_addr), 32'(17 + i));
      check("gap_data",    bram_data,      32'(10 * i));
      check("gap_old_rd",  rd_data,        32'(i));
      check("gap_rd_vld",  32'(rd_valid),  32'd1);
      check("gap_done",    32'(done),      32'(i == 9));
      if (i < 9) begin
        for (int g = 0; g < 3; g++) begin
          step();
          check("gap_idle_we", 32'(bram_we), 32'd0);
          check("gap_rd_vld0", 32'(rd_valid), 32'd0);
        end
      end
    end
    check("gap_checksum", checksum, 32'd450);

    // Overflow with eleven beats 101..111
    do_clear();
    for (int i = 1; i <= 11; i++) begin
      beat(32'(100 + i));
      check("ovf_we",    32'(bram_we),  32'(i <= 9));
      check("ovf_flag",  32'(overflow), 32'(i >= 10));
      check("ovf_count", 32'(count),    32'(i <= 9 ? i : 9));
    end
    check("ovf_checksum", checksum, 32'd945);
    // Beat with clear is dropped
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    do_clear();
    in_valid = 1'b0;
    check("ovf_clr_flag",  32'(overflow), 32'd0);
    check("ovf_clr_count", 32'(count),    32'd0);
    check("ovf_clr_we",    32'(bram_we),  32'd0);
    check("ovf_clr_cksum", checksum,      32'd0);

    // Reset after 4 beats aborts the capture
    for (int i = 1; i <= 4; i++) beat(32'(200 + i));
    check("rst4_count", 32'(count), 32'd4);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd999;
    step();
    in_valid = 1'b0;
    reset    = 1'b0;
    check("rst4_we",    32'(bram_we), 32'd0);
    check("rst4_count0", 32'(count),  32'd0);
    step();
    check("rst4_we2",   32'(bram_we), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      beat(32'(300 + i));
      check("fresh_addr", 32'(bram_addr), 32'(17 + i));
      check("fresh_we",   32'(bram_we),   32'd1);
    end
    check("fresh_done", 32'(done), 32'd1);

    // Checksum wrap and readback
    do_clear();
    beat(32'hFFFF_FFFF);
    beat(32'hFFFF_FFFF);
    check("wrap_checksum", checksum, 32'hFFFF_FFFE);
    rd_en  = 1'b1;
    rd_idx = 4'd1;
    step();
    check("rd1_data",  rd_data,        32'hFFFF_FFFF);
    check("rd1_err",   32'(rd_err),    32'd0);
    check("rd1_valid", 32'(rd_valid),  32'd1);
    rd_idx = 4'd12;
    step();
    check("rd12_data",  rd_data,       32'd0);
    check("rd12_err",   32'(rd_err),   32'd1);
    check("rd12_valid", 32'(rd_valid), 32'd1);
    rd_en = 1'b0;
    step();
    check("rd_off_valid", 32'(rd_valid), 32'd0);
    check("rd_off_err",   32'(rd_err),   32'd0);
    // Index 8 still holds the last word of the fresh run
    rd_en  = 1'b1;
    rd_idx = 4'd8;
    step();
    rd_en = 1'b0;
    check("rd8_data", rd_data, 32'd309);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
